// File: rtl/jtag_tap_core.sv
// IEEE 1149.1 TAP controller with IR, BYPASS, IDCODE and one USER data register.
// Shift/capture/update take effect on rising TCK; TDO/TDO_EN are retimed on falling TCK.
module jtag_tap_core #(
  parameter int          IR_WIDTH   = 4,
  parameter int          DR_WIDTH   = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h0A5A_5001,
  parameter int          IDCODE_OP  = 1,
  parameter int          USER_OP    = 2
) (
  input  logic                TCK,
  input  logic                TRST_N,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  output logic [3:0]          state_obs,
  output logic [IR_WIDTH-1:0] ir_out,
  input  logic [DR_WIDTH-1:0] user_capture,
  output logic [DR_WIDTH-1:0] user_dr_out,
  output logic                user_update
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_t;

  state_t              state;
  state_t              state_nxt;
  dr_sel_t             dr_sel;
  logic [IR_WIDTH-1:0] ir_sr;
  logic                bypass_sr;
  logic [31:0]         idcode_sr;
  logic [DR_WIDTH-1:0] user_sr;
  logic [DR_WIDTH:0]   user_cat;
  logic                tdo_nxt;

  assign state_obs = state;
  assign user_cat  = {TDI, user_sr};

  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir_out == IR_WIDTH'(IDCODE_OP))
      dr_sel = DR_IDCODE;
    else if (ir_out == IR_WIDTH'(USER_OP))
      dr_sel = DR_USER;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TLR:    state_nxt = TMS ? TLR    : RTI;
      RTI:    state_nxt = TMS ? SEL_DR : RTI;
      SEL_DR: state_nxt = TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_nxt = TMS ? EX1_DR : SH_DR;
      SH_DR:  state_nxt = TMS ? EX1_DR : SH_DR;
      EX1_DR: state_nxt = TMS ? UPD_DR : PAU_DR;
      PAU_DR: state_nxt = TMS ? EX2_DR : PAU_DR;
      EX2_DR: state_nxt = TMS ? UPD_DR : SH_DR;
      UPD_DR: state_nxt = TMS ? SEL_DR : RTI;
      SEL_IR: state_nxt = TMS ? TLR    : CAP_IR;
      CAP_IR: state_nxt = TMS ? EX1_IR : SH_IR;
      SH_IR:  state_nxt = TMS ? EX1_IR : SH_IR;
      EX1_IR: state_nxt = TMS ? UPD_IR : PAU_IR;
      PAU_IR: state_nxt = TMS ? EX2_IR : PAU_IR;
      EX2_IR: state_nxt = TMS ? UPD_IR : SH_IR;
      UPD_IR: state_nxt = TMS ? SEL_DR : RTI;
      default: state_nxt = TLR;
    endcase
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      state       <= TLR;
      ir_out      <= IR_WIDTH'(IDCODE_OP);
      ir_sr       <= '0;
      bypass_sr   <= 1'b0;
      idcode_sr   <= '0;
      user_sr     <= '0;
      user_dr_out <= '0;
      user_update <= 1'b0;
    end else begin
      state       <= state_nxt;
      user_update <= 1'b0;
      case (state)
        TLR:    ir_out <= IR_WIDTH'(IDCODE_OP);
        CAP_IR: ir_sr  <= IR_WIDTH'(2'b01);
        SH_IR:  ir_sr  <= {TDI, ir_sr[IR_WIDTH-1:1]};
        UPD_IR: ir_out <= ir_sr;
        CAP_DR: begin
          case (dr_sel)
            DR_IDCODE: idcode_sr <= IDCODE_VAL;
            DR_USER:   user_sr   <= user_capture;
            default:   bypass_sr <= 1'b0;
          endcase
        end
        SH_DR: begin
          case (dr_sel)
            DR_IDCODE: idcode_sr <= {TDI, idcode_sr[31:1]};
            DR_USER:   user_sr   <= user_cat[DR_WIDTH:1];
            default:   bypass_sr <= TDI;
          endcase
        end
        UPD_DR: begin
          // Only USER has a parallel side; BYPASS/IDCODE updates are silent.
          if (dr_sel == DR_USER) begin
            user_dr_out <= user_sr;
            user_update <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tdo_nxt = 1'b0;
    if (state == SH_IR)
      tdo_nxt = ir_sr[0];
    else if (state == SH_DR) begin
      case (dr_sel)
        DR_IDCODE: tdo_nxt = idcode_sr[0];
        DR_USER:   tdo_nxt = user_sr[0];
        default:   tdo_nxt = bypass_sr;
      endcase
    end
  end

  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else begin
      TDO    <= tdo_nxt;
      TDO_EN <= (state == SH_IR) || (state == SH_DR);
    end
  end

endmodule

// File: tb/tb_jtag_tap_core.sv
// Directed bench for jtag_tap_core: reset, IDCODE read, IR load, USER write with pause, BYPASS, TLR and async reset.
module tb_jtag_tap_core;

  logic       TCK = 1'b0;
  logic       TRST_N = 1'b0;
  logic       TMS = 1'b1;
  logic       TDI = 1'b0;
  logic       TDO;
  logic       TDO_EN;
  logic [3:0] state_obs;
  logic [3:0] ir_out;
  logic [7:0] user_capture = 8'h3C;
  logic [7:0] user_dr_out;
  logic       user_update;

  int checks = 0;
  int errors = 0;

  jtag_tap_core dut (
    .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI),
    .TDO(TDO), .TDO_EN(TDO_EN), .state_obs(state_obs), .ir_out(ir_out),
    .user_capture(user_capture), .user_dr_out(user_dr_out), .user_update(user_update)
  );

  always #5 TCK = ~TCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // TDO/TDO_EN are sampled before the rising edge that consumes TMS/TDI.
  task automatic step(input logic tms, input logic tdi, output logic tdo_b, output logic en_b);
    tdo_b = TDO;
    en_b  = TDO_EN;
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
    @(negedge TCK);
    #1;
  endtask

  task automatic tms_seq(input logic [7:0] bits, input int n);
    logic d0, d1;
    for (int i = 0; i < n; i++) step(bits[i], 1'b0, d0, d1);
  endtask

  // RTI -> ShIR, shift val, -> UpdIR -> RTI; returns bits seen on TDO.
  task automatic ir_scan(input logic [3:0] val, output logic [3:0] seen);
    logic en;
    tms_seq(8'b0000_0011, 4);
    for (int i = 0; i < 4; i++) step(i == 3, val[i], seen[i], en);
    tms_seq(8'b0000_0001, 2);
  endtask

  logic [31:0] word;
  logic [3:0]  nib;
  logic        b, en, en_any;
  int          en_cnt;

  initial begin
    #12;
    chk("rst_state", state_obs, 0);
    chk("rst_ir", ir_out, 4'h1);
    chk("rst_user_dr", user_dr_out, 0);
    chk("rst_update", user_update, 0);
    chk("rst_tdo", {TDO_EN, TDO}, 0);
    TRST_N = 1'b1;

    en_any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, b, en);
      en_any |= en | TDO_EN;
    end
    chk("tlr_hold_state", state_obs, 0);
    chk("tlr_hold_ir", ir_out, 4'h1);
    chk("tlr_tdo_en", en_any, 0);

    // IDCODE read: TLR -> RTI -> SelDR -> CapDR -> ShDR
    tms_seq(8'b0000_0010, 4);
    chk("shdr_state", state_obs, 4);
    en_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step(i == 31, 1'b0, word[i], en);
      if (en) en_cnt++;
    end
    chk("idcode_value", word, 32'h0A5A5001);
    chk("idcode_en_cnt", en_cnt, 32);
    chk("ex1dr_state", state_obs, 5);
    chk("ex1dr_tdo_en", TDO_EN, 0);
    tms_seq(8'b0000_0001, 1);
    chk("upddr_state", state_obs, 8);
    tms_seq(8'b0000_0000, 1);
    chk("idcode_no_update", user_update, 0);
    chk("rti_state", state_obs, 1);

    ir_scan(4'h2, nib);
    chk("ir_capture_01", nib, 4'h1);
    chk("ir_user", ir_out, 4'h2);

    // USER write with a pause midway through the shift
    tms_seq(8'b0000_0001, 3);
    for (int i = 0; i < 4; i++) step(i == 3, 8'hA5 >> i, word[i], en);
    tms_seq(8'b0000_0000, 2);
    chk("paudr_state", state_obs, 6);
    chk("paudr_tdo_en", TDO_EN, 0);
    tms_seq(8'b0000_0001, 2);
    chk("resume_state", state_obs, 4);
    for (int i = 4; i < 8; i++) step(i == 7, 8'hA5 >> i, word[i], en);
    chk("user_capture_out", word[7:0], 8'h3C);
    tms_seq(8'b0000_0001, 1);
    chk("user_before_upd", user_dr_out, 0);
    tms_seq(8'b0000_0000, 1);
    chk("user_dr_value", user_dr_out, 8'hA5);
    chk("user_update_hi", user_update, 1);
    tms_seq(8'b0000_0000, 1);
    chk("user_update_lo", user_update, 0);

    ir_scan(4'hF, nib);
    chk("ir_bypass", ir_out, 4'hF);
    tms_seq(8'b0000_0001, 3);
    for (int i = 0; i < 4; i++) step(i == 3, 4'b1101 >> i, nib[i], en);
    chk("bypass_tdo", nib, 4'hA);
    tms_seq(8'b0000_0001, 1);
    chk("bypass_state_upd", state_obs, 8);
    tms_seq(8'b0000_0000, 1);
    chk("bypass_no_update", {user_update, user_dr_out}, 9'h0A5);

    tms_seq(8'b0001_1111, 5);
    chk("tms5_state", state_obs, 0);
    chk("tms5_ir", ir_out, 4'h1);
    chk("tms5_user_held", user_dr_out, 8'hA5);

    // Async reset in the middle of a USER shift
    tms_seq(8'b0000_0000, 1);
    ir_scan(4'h2, nib);
    chk("ir_user2", ir_out, 4'h2);
    tms_seq(8'b0000_0001, 3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, b, en);
    chk("mid_shift_en", TDO_EN, 1);
    TRST_N = 1'b0;
    #1;
    chk("trst_state", state_obs, 0);
    chk("trst_ir", ir_out, 4'h1);
    chk("trst_user_dr", user_dr_out, 0);
    chk("trst_tdo_en", TDO_EN, 0);
    en_any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge TCK);
      #1;
      en_any |= user_update;
    end
    chk("trst_no_update", en_any, 0);
    @(negedge TCK);
    #1;
    TRST_N = 1'b1;
    tms_seq(8'b0000_0000, 1);
    chk("post_trst_state", state_obs, 1);
    chk("post_trst_update", user_update, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
